ns_traffic_tester: RTL



---
 rtl/ns_traffic_tester_pkg.sv | 38 +++
 rtl/ns_traffic_tester_if.sv | 16 +
 rtl/ns_traffic_tester_calc_redun.sv | 23 ++
 rtl/ns_traffic_tester.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ns_traffic_tester_pkg.sv
// Shared definitions for ns_traffic_tester: field-size defaults, on/off constants,
// source/sink FSM state encodings and a saturating counter helper.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_ON
`define NS_ON 1'b1
`endif
`ifndef NS_OFF
`define NS_OFF 1'b0
`endif

package ns_traffic_tester_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_REQ  = 2'd2,
    S_DROP = 2'd3
  } src_state_e;

  typedef enum logic [1:0] {
    K_IDLE  = 2'd0,
    K_CHECK = 2'd1,
    K_ACK   = 2'd2
  } snk_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ns_traffic_tester_if.sv
// Four-phase message channel: master drives the fields and req, slave returns ack.
interface ns_traffic_tester_if #(
  parameter int unsigned ASZ = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ = `NS_DATA_SIZE,
  parameter int unsigned RSZ = `NS_REDUN_SIZE
) ();
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output src, dst, dat, red, req, input ack);
  modport slave  (input src, dst, dat, red, req, output ack);
endinterface

// File: rtl/ns_traffic_tester_calc_redun.sv
// Message redundancy: XOR-fold of {src,dst,dat} into RSZ bits (bit i lands on i mod RSZ).
module calc_redun #(
  parameter int unsigned ASZ = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ = `NS_DATA_SIZE,
  parameter int unsigned RSZ = `NS_REDUN_SIZE
) (
  input  logic [ASZ-1:0] src_i,
  input  logic [ASZ-1:0] dst_i,
  input  logic [DSZ-1:0] dat_i,
  output logic [RSZ-1:0] red_o
);
  localparam int unsigned TW = 2*ASZ + DSZ;

  logic [TW-1:0] flat;

  always_comb begin
    flat  = {src_i, dst_i, dat_i};
    red_o = '0;
    for (int unsigned i = 0; i < TW; i++) begin
      red_o[i % RSZ] = red_o[i % RSZ] ^ flat[i];
    end
  end
endmodule

// File: rtl/ns_traffic_tester.sv
// Message traffic generator (o0) and checker (i0) for messaging-fabric bring-up.
// Optional feature: define NS_TRAFFIC_ERR_INJECT_EN to corrupt red bit 0 of every INJ_PERIOD-th message.
module ns_traffic_tester
  import ns_traffic_tester_pkg::*;
#(
  parameter int unsigned MY_ADDR    = 9,
  parameter int unsigned MIN_ADDR   = 1,
  parameter int unsigned MAX_ADDR   = 1,
  parameter int unsigned NUM_MSG    = 0,
  parameter int unsigned INJ_PERIOD = 8,
  parameter int unsigned ASZ        = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ        = `NS_DATA_SIZE,
  parameter int unsigned RSZ        = `NS_REDUN_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  ns_traffic_tester_if.master       o0,
  ns_traffic_tester_if.slave        i0,
  output logic                      done,
  output logic [7:0]                err_cnt,
  output logic [3:0]                dbg_leds,
  output logic [3:0]                dbg_disp0,
  output logic [3:0]                dbg_disp1
);
  localparam int unsigned NUM_DST = MAX_ADDR - MIN_ADDR + 1;
  localparam int unsigned IW      = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
  localparam logic [ASZ-1:0] MY_A  = ASZ'(MY_ADDR);
  localparam logic [ASZ-1:0] MIN_A = ASZ'(MIN_ADDR);
  localparam logic [ASZ-1:0] MAX_A = ASZ'(MAX_ADDR);
`ifdef NS_TRAFFIC_ERR_INJECT_EN
  localparam logic INJ_EN = `NS_ON;
`else
  localparam logic INJ_EN = `NS_OFF;
`endif

  // ---------------- source ----------------
  src_state_e     s_state_q, s_state_d;
  logic [ASZ-1:0] cur_dst_q, cur_dst_d;
  logic [ASZ-1:0] o_dst_q, o_dst_d;
  logic [DSZ-1:0] o_dat_q, o_dat_d;
  logic [RSZ-1:0] o_red_q, o_red_d;
  logic           req_q, req_d;
  logic [31:0]    sent_q, sent_d;
  logic [31:0]    inj_cnt_q, inj_cnt_d;
  logic           done_q, done_d;
  logic [DSZ-1:0] seq_q [NUM_DST];
  logic [DSZ-1:0] seq_d [NUM_DST];
  logic [IW-1:0]  cur_idx, o_idx;
  logic [RSZ-1:0] src_red;

  assign cur_idx = IW'(cur_dst_q - MIN_A);
  assign o_idx   = IW'(o_dst_q - MIN_A);

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_src_redun (
    .src_i (MY_A),
    .dst_i (cur_dst_q),
    .dat_i (seq_q[cur_idx]),
    .red_o (src_red)
  );

  always_comb begin
    s_state_d = s_state_q;
    cur_dst_d = cur_dst_q;
    o_dst_d   = o_dst_q;
    o_dat_d   = o_dat_q;
    o_red_d   = o_red_q;
    sent_d    = sent_q;
    inj_cnt_d = inj_cnt_q;
    done_d    = done_q;
    seq_d     = seq_q;
    unique case (s_state_q)
      S_IDLE: if (enable && !done_q) s_state_d = S_LOAD;
      S_LOAD: begin
        o_dst_d = cur_dst_q;
        o_dat_d = seq_q[cur_idx];
        o_red_d = src_red;
        if (INJ_EN && (inj_cnt_q == INJ_PERIOD - 1)) o_red_d[0] = ~src_red[0];
        s_state_d = S_REQ;
      end
      S_REQ: if (o0.ack) begin
        seq_d[o_idx] = seq_q[o_idx] + DSZ'(1);
        cur_dst_d    = (cur_dst_q == MAX_A) ? MIN_A : cur_dst_q + ASZ'(1);
        sent_d       = sent_q + 32'd1;
        inj_cnt_d    = (inj_cnt_q == INJ_PERIOD - 1) ? '0 : inj_cnt_q + 32'd1;
        s_state_d    = S_DROP;
      end
      S_DROP: if (!o0.ack) begin
        if ((NUM_MSG != 0) && (sent_q == NUM_MSG)) begin
          done_d    = `NS_ON;
          s_state_d = S_IDLE;
        end else begin
          s_state_d = enable ? S_LOAD : S_IDLE;
        end
      end
      default: s_state_d = S_IDLE;
    endcase
    // req is registered from the state so it rises one cycle after S_REQ is entered
    req_d = (s_state_q == S_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_state_q <= S_IDLE;
      cur_dst_q <= MIN_A;
      o_dst_q   <= MIN_A;
      o_dat_q   <= '0;
      o_red_q   <= '0;
      req_q     <= 1'b0;
      sent_q    <= '0;
      inj_cnt_q <= '0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_DST; i++) seq_q[i] <= '0;
    end else begin
      s_state_q <= s_state_d;
      cur_dst_q <= cur_dst_d;
      o_dst_q   <= o_dst_d;
      o_dat_q   <= o_dat_d;
      o_red_q   <= o_red_d;
      req_q     <= req_d;
      sent_q    <= sent_d;
      inj_cnt_q <= inj_cnt_d;
      done_q    <= done_d;
      seq_q     <= seq_d;
    end
  end

  assign o0.src = MY_A;
  assign o0.dst = o_dst_q;
  assign o0.dat = o_dat_q;
  assign o0.red = o_red_q;
  assign o0.req = req_q;

  // ---------------- sink ----------------
  snk_state_e     k_state_q, k_state_d;
  logic [ASZ-1:0] k_src_q, k_src_d;
  logic [ASZ-1:0] k_dst_q, k_dst_d;
  logic [DSZ-1:0] k_dat_q, k_dat_d;
  logic [RSZ-1:0] k_red_q, k_red_d;
  logic           ack_q, ack_d;
  logic [DSZ-1:0] exp_q [NUM_DST];
  logic [DSZ-1:0] exp_d [NUM_DST];
  logic           exp_vld_q [NUM_DST];
  logic           exp_vld_d [NUM_DST];
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic           red_err_q, red_err_d;
  logic           seq_err_q, seq_err_d;
  logic           addr_err_q, addr_err_d;
  logic [3:0]     disp0_q, disp0_d;
  logic [3:0]     disp1_q, disp1_d;
  logic [ASZ-1:0] k_off;
  logic           k_in_range;
  logic [IW-1:0]  k_idx;
  logic [RSZ-1:0] k_red_calc;
  logic           err_hit;

  // out-of-range below MIN_ADDR wraps to a large offset, so one compare covers both ends
  assign k_off      = k_dst_q - MIN_A;
  assign k_in_range = (32'(k_off) < NUM_DST);
  assign k_idx      = IW'(k_off);

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_snk_redun (
    .src_i (k_src_q),
    .dst_i (k_dst_q),
    .dat_i (k_dat_q),
    .red_o (k_red_calc)
  );

  always_comb begin
    k_state_d  = k_state_q;
    k_src_d    = k_src_q;
    k_dst_d    = k_dst_q;
    k_dat_d    = k_dat_q;
    k_red_d    = k_red_q;
    exp_d      = exp_q;
    exp_vld_d  = exp_vld_q;
    err_cnt_d  = err_cnt_q;
    red_err_d  = red_err_q;
    seq_err_d  = seq_err_q;
    addr_err_d = addr_err_q;
    disp0_d    = disp0_q;
    disp1_d    = disp1_q;
    err_hit    = 1'b0;
    unique case (k_state_q)
      K_IDLE: if (i0.req && !ack_q) begin
        k_src_d   = i0.src;
        k_dst_d   = i0.dst;
        k_dat_d   = i0.dat;
        k_red_d   = i0.red;
        k_state_d = K_CHECK;
      end
      K_CHECK: begin
        // a corrupted message teaches nothing, so the expectation is left untouched
        if (k_red_calc != k_red_q) begin
          red_err_d = `NS_ON;
          err_hit   = 1'b1;
        end else if (!k_in_range) begin
          addr_err_d = `NS_ON;
          err_hit    = 1'b1;
        end else begin
          if (exp_vld_q[k_idx] && (k_dat_q != exp_q[k_idx])) begin
            seq_err_d = `NS_ON;
            err_hit   = 1'b1;
            if (!seq_err_q) begin
              disp0_d = 4'(exp_q[k_idx]);
              disp1_d = 4'(k_dat_q);
            end
          end
          exp_d[k_idx]     = k_dat_q + DSZ'(1);
          exp_vld_d[k_idx] = 1'b1;
        end
        if (err_hit) err_cnt_d = sat_inc8(err_cnt_q);
        k_state_d = K_ACK;
      end
      K_ACK: if (!i0.req) k_state_d = K_IDLE;
      default: k_state_d = K_IDLE;
    endcase
    ack_d = (k_state_q == K_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_state_q  <= K_IDLE;
      k_src_q    <= '0;
      k_dst_q    <= '0;
      k_dat_q    <= '0;
      k_red_q    <= '0;
      ack_q      <= 1'b0;
      err_cnt_q  <= '0;
      red_err_q  <= 1'b0;
      seq_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
      disp0_q    <= '0;
      disp1_q    <= '0;
      for (int unsigned i = 0; i < NUM_DST; i++) begin
        exp_q[i]     <= '0;
        exp_vld_q[i] <= 1'b0;
      end
    end else begin
      k_state_q  <= k_state_d;
      k_src_q    <= k_src_d;
      k_dst_q    <= k_dst_d;
      k_dat_q    <= k_dat_d;
      k_red_q    <= k_red_d;
      ack_q      <= ack_d;
      err_cnt_q  <= err_cnt_d;
      red_err_q  <= red_err_d;
      seq_err_q  <= seq_err_d;
      addr_err_q <= addr_err_d;
      disp0_q    <= disp0_d;
      disp1_q    <= disp1_d;
      exp_q      <= exp_d;
      exp_vld_q  <= exp_vld_d;
    end
  end

  assign i0.ack    = ack_q;
  assign done      = done_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_leds  = {done_q, addr_err_q, seq_err_q, red_err_q};
  assign dbg_disp0 = disp0_q;
  assign dbg_disp1 = disp1_q;

endmodule
